// File: rtl/moldudp64_pkg.sv
// Shared widths, parser state encoding and output-beat record for the MoldUDP64 parser.
package moldudp64_pkg;

  localparam int unsigned LEN    = 8;
  localparam int unsigned ML_W   = 2 * LEN;
  localparam int unsigned SID_W  = 10 * LEN;
  localparam int unsigned SEQ_W  = 8 * LEN;
  localparam int unsigned MH_W   = 20 * LEN;
  localparam int unsigned NREC   = 4;
  localparam int unsigned QDEPTH = 4;

  typedef enum logic [2:0] {IDLE, HDR, MSG_LEN, MSG_DATA, DROP} state_e;

  typedef struct packed {
    logic            start;
    logic [ML_W-1:0] len;
    logic [7:0]      mask;
    logic [63:0]     data;
  } beat_t;

  function automatic logic [7:0] lane_mask(input logic [3:0] n);
    return 8'hFF >> (4'd8 - n);
  endfunction

endpackage

// File: rtl/mold_realign.sv
// Byte realignment buffer: carries up to 7 message bytes and shift-merges new lanes behind them.
module mold_realign
  import moldudp64_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        data,
  input  logic [7:0]         is_data,
  input  logic [7:0]         first,
  input  logic [7:0]         last,
  input  logic [8*ML_W-1:0]  lane_len,
  input  logic               dg_end,
  input  logic               dg_err,
  output beat_t              rec [NREC],
  output logic [NREC-1:0]    rec_v
);

  logic [63:0]     buf_q, buf_n;
  logic [3:0]      cnt_q, cnt_n;
  logic            start_q, start_n;
  logic [ML_W-1:0] len_q, len_n;
  int unsigned     nrec;
  logic            emit;

  always_comb begin
    buf_n   = buf_q;
    cnt_n   = cnt_q;
    start_n = start_q;
    len_n   = len_q;
    nrec    = 0;
    emit    = 1'b0;
    rec     = '{default: '0};
    rec_v   = '0;
    for (int unsigned l = 0; l < 8; l++) begin
      if (is_data[l]) begin
        if (first[l]) begin
          start_n = 1'b1;
          len_n   = lane_len[l*ML_W +: ML_W];
        end
        // lanes above cnt are always zero, so OR-ing in the shifted byte is a merge
        buf_n = buf_n | (64'(data[l*8 +: 8]) << {cnt_n, 3'b000});
        cnt_n = cnt_n + 4'd1;
        emit  = (cnt_n == 4'd8) || last[l];
        for (int unsigned s = 0; s < NREC; s++) begin
          if (emit && s == nrec) begin
            rec[s]   = '{start: start_n, len: len_n, mask: lane_mask(cnt_n), data: buf_n};
            rec_v[s] = 1'b1;
          end
        end
        if (emit) begin
          nrec    = nrec + 1;
          buf_n   = '0;
          cnt_n   = '0;
          start_n = 1'b0;
        end
      end
    end
    if (dg_end) begin
      for (int unsigned s = 0; s < NREC; s++) begin
        if (!dg_err && cnt_n != 4'd0 && s == nrec) begin
          rec[s]   = '{start: start_n, len: len_n, mask: lane_mask(cnt_n), data: buf_n};
          rec_v[s] = 1'b1;
        end
      end
      buf_n   = '0;
      cnt_n   = '0;
      start_n = 1'b0;
      len_n   = '0;
    end
    if (dg_err) rec_v = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      len_q   <= '0;
    end else begin
      buf_q   <= buf_n;
      cnt_q   <= cnt_n;
      start_q <= start_n;
      len_q   <= len_n;
    end
  end

endmodule

// File: rtl/top.sv
// MoldUDP64 parser: UDP payload beats in, one registered message beat out per cycle.
// Define MOLD_HDR_OUT_EN to expose the session id, sequence number and message count.
module top #(
  parameter int unsigned AXI_DATA_W = 64,
  parameter int unsigned LEN        = moldudp64_pkg::LEN
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           upd_axis_tvalid_i,
  input  logic [AXI_DATA_W/8-1:0]        upd_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0]          upd_axis_tdata_i,
  input  logic                           upd_axis_tlast_i,
  input  logic                           upd_axis_tuser_i,
  output logic                           upd_axis_tready_o,
  output logic                           mold_msg_v_o,
  output logic                           mold_msg_start_o,
  output logic [moldudp64_pkg::ML_W-1:0] mold_msg_len_o,
  output logic [AXI_DATA_W/8-1:0]        mold_msg_mask_o,
  output logic [AXI_DATA_W-1:0]          mold_msg_data_o
`ifdef MOLD_HDR_OUT_EN
  ,
  output logic [moldudp64_pkg::SID_W-1:0] mold_sid_o,
  output logic [moldudp64_pkg::SEQ_W-1:0] mold_seq_num_o,
  output logic [moldudp64_pkg::ML_W-1:0]  mold_msg_cnt_o
`endif
);
  import moldudp64_pkg::*;

  localparam int unsigned AXI_KEEP_W = AXI_DATA_W / 8;

  state_e          state, state_n, ph;
  logic            hdr2, hdr2_n, len_half, len_half_n;
  logic [LEN-1:0]  len_lo, len_lo_n, b;
  logic [ML_W-1:0] rem, rem_n, cur_len, cur_len_n, msg_left, msg_left_n;
  int unsigned     walk_from;
  logic [AXI_KEEP_W-1:0] is_data, first, last;
  logic [8*ML_W-1:0]     lane_len;
  beat_t           rec [NREC];
  logic [NREC-1:0] rec_v;
  beat_t           q [QDEPTH];
  beat_t           q_n [QDEPTH];
  beat_t           all [QDEPTH+NREC];
  logic [2:0]      q_cnt, q_cnt_n;
  int unsigned     n;

  assign upd_axis_tready_o = 1'b1;

  // Byte walk: classifies each lane as length, message data or dropped.
  always_comb begin
    state_n = state; hdr2_n = hdr2; len_half_n = len_half; len_lo_n = len_lo;
    rem_n = rem; cur_len_n = cur_len; msg_left_n = msg_left;
    is_data = '0; first = '0; last = '0; lane_len = '0;
    walk_from = 8; ph = state; b = '0;
    if (upd_axis_tvalid_i) begin
      case (state)
        IDLE: begin state_n = HDR; hdr2_n = 1'b0; end
        HDR: begin
          if (!hdr2) hdr2_n = 1'b1;
          else begin
            msg_left_n = {upd_axis_tdata_i[3*LEN +: LEN], upd_axis_tdata_i[2*LEN +: LEN]};
            len_half_n = 1'b0;
            ph = (msg_left_n == '0 || msg_left_n == '1) ? DROP : MSG_LEN;
            walk_from = 4;
          end
        end
        default: walk_from = 0;
      endcase
      for (int unsigned l = 0; l < AXI_KEEP_W; l++) begin
        if (l >= walk_from && upd_axis_tkeep_i[l]) begin
          b = upd_axis_tdata_i[l*LEN +: LEN];
          case (ph)
            MSG_LEN: begin
              if (!len_half_n) begin
                len_lo_n = b; len_half_n = 1'b1;
              end else begin
                len_half_n = 1'b0;
                if ({b, len_lo_n} == '0) begin
                  msg_left_n = msg_left_n - ML_W'(1);
                  if (msg_left_n == '0) ph = DROP;
                end else begin
                  cur_len_n = {b, len_lo_n}; rem_n = cur_len_n; ph = MSG_DATA;
                end
              end
            end
            MSG_DATA: begin
              is_data[l] = 1'b1;
              first[l]   = (rem_n == cur_len_n);
              lane_len[l*ML_W +: ML_W] = cur_len_n;
              rem_n = rem_n - ML_W'(1);
              if (rem_n == '0) begin
                last[l]    = 1'b1;
                msg_left_n = msg_left_n - ML_W'(1);
                ph = (msg_left_n == '0) ? DROP : MSG_LEN;
              end
            end
            default: ;
          endcase
        end
      end
      if (walk_from < 8) state_n = ph;
      if (upd_axis_tlast_i || upd_axis_tuser_i) begin
        state_n = IDLE; hdr2_n = 1'b0; len_half_n = 1'b0;
      end
    end
  end

  mold_realign u_realign (
    .clk      (clk),
    .rst      (nreset),
    .data     (upd_axis_tdata_i),
    .is_data  (is_data),
    .first    (first),
    .last     (last),
    .lane_len (lane_len),
    .dg_end   (upd_axis_tvalid_i && (upd_axis_tlast_i || upd_axis_tuser_i)),
    .dg_err   (upd_axis_tvalid_i && upd_axis_tuser_i),
    .rec      (rec),
    .rec_v    (rec_v)
  );

  // One beat may finish several messages; extras queue and drain one per cycle.
  always_comb begin
    all = '{default: '0};
    for (int unsigned i = 0; i < QDEPTH; i++)
      if (i < 32'(q_cnt)) all[i] = q[i];
    n = 32'(q_cnt);
    for (int unsigned r = 0; r < NREC; r++) begin
      for (int unsigned s = 0; s < QDEPTH + NREC; s++)
        if (rec_v[r] && s == n) all[s] = rec[r];
      n = n + 32'(rec_v[r]);
    end
    for (int unsigned i = 0; i < QDEPTH; i++) q_n[i] = all[i+1];
    q_cnt_n = (n == 0) ? 3'd0 : (n - 1 > QDEPTH) ? 3'(QDEPTH) : 3'(n - 1);
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state <= IDLE; hdr2 <= 1'b0; len_half <= 1'b0; len_lo <= '0;
      rem <= '0; cur_len <= '0; msg_left <= '0;
      q <= '{default: '0}; q_cnt <= '0;
      mold_msg_v_o <= 1'b0; mold_msg_start_o <= 1'b0; mold_msg_len_o <= '0;
      mold_msg_mask_o <= '0; mold_msg_data_o <= '0;
    end else begin
      state <= state_n; hdr2 <= hdr2_n; len_half <= len_half_n; len_lo <= len_lo_n;
      rem <= rem_n; cur_len <= cur_len_n; msg_left <= msg_left_n;
      q <= q_n; q_cnt <= q_cnt_n;
      mold_msg_v_o     <= (n != 0);
      mold_msg_start_o <= all[0].start;
      mold_msg_len_o   <= all[0].len;
      mold_msg_mask_o  <= all[0].mask;
      mold_msg_data_o  <= all[0].data;
    end
  end

`ifdef MOLD_HDR_OUT_EN
  logic [SID_W+SEQ_W-2*LEN-1:0] hdr_sh;

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      hdr_sh <= '0; mold_sid_o <= '0; mold_seq_num_o <= '0; mold_msg_cnt_o <= '0;
    end else if (upd_axis_tvalid_i) begin
      if (state == IDLE) hdr_sh[63:0] <= upd_axis_tdata_i;
      else if (state == HDR && !hdr2) hdr_sh[127:64] <= upd_axis_tdata_i;
      else if (state == HDR) begin
        mold_sid_o     <= hdr_sh[SID_W-1:0];
        mold_seq_num_o <= {upd_axis_tdata_i[2*LEN-1:0], hdr_sh[127:SID_W]};
        mold_msg_cnt_o <= upd_axis_tdata_i[4*LEN-1:2*LEN];
      end
    end
  end
`endif

endmodule

// File: tb/tb_top.sv
// Directed bench for the MoldUDP64 parser: hand-computed output beats checked by immediate assertions.
module tb_top;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic [7:0]  tkeep = '0;
  logic [63:0] tdata = '0;
  logic        tready, v, start;
  logic [15:0] len;
  logic [7:0]  mask;
  logic [63:0] data;
`ifdef MOLD_HDR_OUT_EN
  logic [79:0] sid;
  logic [63:0] seq;
  logic [15:0] cnt;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  top dut (
    .clk               (clk),
    .nreset            (nreset),
    .upd_axis_tvalid_i (tvalid),
    .upd_axis_tkeep_i  (tkeep),
    .upd_axis_tdata_i  (tdata),
    .upd_axis_tlast_i  (tlast),
    .upd_axis_tuser_i  (tuser),
    .upd_axis_tready_o (tready),
    .mold_msg_v_o      (v),
    .mold_msg_start_o  (start),
    .mold_msg_len_o    (len),
    .mold_msg_mask_o   (mask),
    .mold_msg_data_o   (data)
`ifdef MOLD_HDR_OUT_EN
    ,
    .mold_sid_o        (sid),
    .mold_seq_num_o    (seq),
    .mold_msg_cnt_o    (cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat_chk(input string tag, input logic ev, input logic es,
                          input logic [15:0] el, input logic [7:0] em, input logic [63:0] ed);
    check({tag, ".v"}, 64'(v), 64'(ev));
    if (ev) begin
      check({tag, ".start"}, 64'(start), 64'(es));
      if (es) check({tag, ".len"}, 64'(len), 64'(el));
      check({tag, ".mask"}, 64'(mask), 64'(em));
      check({tag, ".data"}, data, ed);
    end
  endtask

  task automatic cyc(input logic [7:0] keep, input logic [63:0] d, input logic last, input logic user);
    tvalid = 1'b1; tkeep = keep; tdata = d; tlast = last; tuser = user;
    @(posedge clk); #1;
    tvalid = 1'b0; tkeep = '0; tdata = '0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // tail holds beat 2 lanes 4-7 (lane 4 in the low byte)
  task automatic hdr(input logic [15:0] count, input logic [31:0] tail, input logic gap);
    cyc(8'hFF, 64'h00000000_DEADBEEF, 1'b0, 1'b0);
    if (gap) idle();
    cyc(8'hFF, 64'hF0F0F0F0_F0F00000, 1'b0, 1'b0);
    if (gap) idle();
    cyc(8'hFF, {tail, count, 16'hF0F0}, 1'b0, 1'b0);
  endtask

  task automatic run31(input string tag, input logic gap, input logic [15:0] ln);
    hdr(16'd1, {16'hFFFF, ln}, gap);
    beat_chk({tag, "_h2"}, 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);
    if (gap) idle();
    cyc(8'hFF, 64'hAAAAAAAA_AAAAAAAA, 1'b0, 1'b0);
    beat_chk({tag, "_a"}, 1'b1, 1'b1, ln, 8'hFF, 64'hAAAAAAAA_AAAAFFFF);
    if (gap) begin
      idle();
      beat_chk({tag, "_gap"}, 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);
    end
    cyc(8'h0F, 64'h00000000_BBBBBBBB, 1'b1, 1'b0);
    beat_chk({tag, "_b"}, 1'b1, 1'b0, 16'd0, 8'h3F, 64'h0000BBBB_BBBBAAAA);
    idle();
    beat_chk({tag, "_end"}, 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);
  endtask

  initial begin
    idle(); idle();
    check("rst.v", 64'(v), 64'd0);
    check("rst.start", 64'(start), 64'd0);
    check("rst.len", 64'(len), 64'd0);
    check("rst.mask", 64'(mask), 64'd0);
    check("rst.data", data, 64'd0);
    check("rst.tready", 64'(tready), 64'd1);
    nreset = 1'b0;
    idle();

    run31("r31", 1'b0, 16'd14);
    run31("r32", 1'b0, 16'd16);

    hdr(16'd2, 32'h22110003, 1'b0);
    beat_chk("r33_h2", 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);
    cyc(8'hFF, 64'h88776655_44000533, 1'b1, 1'b0);
    beat_chk("r33_m1", 1'b1, 1'b1, 16'd3, 8'h07, 64'h00000000_00332211);
    idle();
    beat_chk("r33_m2", 1'b1, 1'b1, 16'd5, 8'h1F, 64'h00000088_77665544);
    idle();
    beat_chk("r33_end", 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);

    hdr(16'd3, 32'h00010000, 1'b0);
    beat_chk("zl_h2", 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);
    cyc(8'h1F, 64'h0000003C_C300027E, 1'b1, 1'b0);
    beat_chk("zl_m2", 1'b1, 1'b1, 16'd1, 8'h01, 64'h00000000_0000007E);
    idle();
    beat_chk("zl_m3", 1'b1, 1'b1, 16'd2, 8'h03, 64'h00000000_00003CC3);
    idle();
    beat_chk("zl_end", 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);

    hdr(16'd2, 32'h039C0001, 1'b0);
    idle();
    beat_chk("strad_m1", 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);
    cyc(8'h0F, 64'h00000000_D3D2D100, 1'b1, 1'b0);
    beat_chk("strad_m2", 1'b1, 1'b1, 16'd3, 8'h07, 64'h00000000_00D3D2D1);

    hdr(16'd0, 32'hFFFF000E, 1'b0);
    cyc(8'hFF, 64'hAAAAAAAA_AAAAAAAA, 1'b1, 1'b0);
    beat_chk("cnt0", 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);
    hdr(16'hFFFF, 32'hFFFF000E, 1'b0);
    cyc(8'hFF, 64'hAAAAAAAA_AAAAAAAA, 1'b1, 1'b0);
    beat_chk("cntffff", 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);

    hdr(16'd1, 32'h22110003, 1'b0);
    cyc(8'hFF, 64'h88776655_44000533, 1'b1, 1'b0);
    beat_chk("exh_m1", 1'b1, 1'b1, 16'd3, 8'h07, 64'h00000000_00332211);
    idle();
    beat_chk("exh_drop", 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);

    hdr(16'd1, 32'hFFFF000E, 1'b0);
    cyc(8'hFF, 64'hAAAAAAAA_AAAAAAAA, 1'b1, 1'b1);
    beat_chk("r34_err", 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);
    idle();
    beat_chk("r34_err2", 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);
    run31("r34_next", 1'b0, 16'd14);

    hdr(16'd1, 32'hFFFF000E, 1'b0);
    cyc(8'hFF, 64'hAAAAAAAA_AAAAAAAA, 1'b0, 1'b0);
    beat_chk("r35_a", 1'b1, 1'b1, 16'd14, 8'hFF, 64'hAAAAAAAA_AAAAFFFF);
    nreset = 1'b1;
    #2;
    check("r35_rst.v", 64'(v), 64'd0);
    check("r35_rst.start", 64'(start), 64'd0);
    check("r35_rst.len", 64'(len), 64'd0);
    check("r35_rst.mask", 64'(mask), 64'd0);
    check("r35_rst.data", data, 64'd0);
    @(posedge clk); #1;
    nreset = 1'b0;
    cyc(8'h0F, 64'h00000000_BBBBBBBB, 1'b1, 1'b0);
    beat_chk("r35_stale", 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);
    idle();
    beat_chk("r35_stale2", 1'b0, 1'b0, 16'd0, 8'h00, 64'd0);
    run31("r35_next", 1'b0, 16'd14);

    run31("r36", 1'b1, 16'd14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter AXI_DATA_W, default 64, AXI stream data width in bits (only 64 supported); AXI_KEEP_W = AXI_DATA_W/8.
REQ-002 Parameter LEN, default 8, bits per byte; ML_W = 2*LEN (16), SID_W = 10*LEN (80), SEQ_W = 8*LEN (64), MH_W = 20*LEN (160).
REQ-003 clk  in  1  sole clock; all state is updated on its rising edge.
REQ-004 nreset  in  1  reset, asynchronous and active-high.
REQ-005 upd_axis_tvalid_i  in  1  input beat valid.
REQ-006 upd_axis_tkeep_i  in  8  byte-lane enables; contiguous from lane 0.
REQ-007 upd_axis_tdata_i  in  64  UDP payload; lane 0 (bits 7:0) is the first byte on the wire.
REQ-008 upd_axis_tlast_i  in  1  last beat of the UDP datagram.
REQ-009 upd_axis_tuser_i  in  1  datagram error flag.
REQ-010 upd_axis_tready_o  out  1  ready; tied to 1 (no backpressure).
REQ-011 mold_msg_v_o  out  1  output message beat valid.
REQ-012 mold_msg_start_o  out  1  beat is the first beat of a message.
REQ-013 mold_msg_len_o  out  16  message length in bytes; meaningful when start is high.
REQ-014 mold_msg_mask_o  out  8  valid byte lanes of mold_msg_data_o, contiguous from lane 0.
REQ-015 mold_msg_data_o  out  64  message bytes; message byte 0 of each beat sits in lane 0.

Function
REQ-016 Header is the first 20 bytes: session id in bytes 0-9, sequence number in bytes 10-17, message count in bytes 18-19; each multi-byte field is taken bit-for-bit, with the lowest wire byte as its LSB.
REQ-017 Beats 0 and 1 carry header bytes 0-15; beat 2 lanes 0-3 carry header bytes 16-19; lanes 4-5 carry the first message length; message data starts at lane 6.
REQ-018 Each message is a 2-byte length, same byte order as REQ-016, followed by that many data bytes; the block SHALL handle length fields and data that straddle beat boundaries.
REQ-019 States: IDLE (await header beat 0), HDR (beats 1-2), MSG_LEN, MSG_DATA, DROP (discard until tlast).
REQ-020 The block SHALL parse exactly min(message count, messages present) messages; count 0 or 0xFFFF yields no output; once the count is exhausted, the remaining bytes go to DROP until tlast.
REQ-021 Output beats are registered; a beat is emitted on the cycle after the input beat that completes 8 message bytes or the final byte of the message.
REQ-022 No output beat SHALL mix bytes of two messages; a zero-length message produces no output beat.
REQ-023 tlast or tuser at any state returns the block to IDLE; a partial message SHALL be flushed on the next cycle with its bytes masked; tuser=1 suppresses that flush.
REQ-024 Cycles with tvalid=0 SHALL hold state; mold_msg_v_o is low whenever no beat completes.

Reset
REQ-025 While nreset is high: state IDLE; mold_msg_v_o=0, mold_msg_start_o=0, mold_msg_mask_o=0, mold_msg_len_o=0, mold_msg_data_o=0; counters and carry buffer cleared; tready stays 1.
REQ-026 Reset asserted mid-datagram SHALL abort the datagram; after release, parsing restarts with the next beat treated as header beat 0.

Configuration
REQ-027 With macro MOLD_HDR_OUT_EN defined, the block SHALL add outputs mold_sid_o (80), mold_seq_num_o (64) and mold_msg_cnt_o (16), registered when header beat 2 is accepted and reset to 0.
REQ-028 Without MOLD_HDR_OUT_EN, those ports and their registers SHALL be absent.

Structure
REQ-029 Width constants (LEN, ML_W, SID_W, SEQ_W, MH_W) and the state enum SHALL live in a shared package moldudp64_pkg.
REQ-030 The byte realignment buffer (carry up to 7 bytes, shift-merge) SHALL be a sub-module mold_realign.

Verification
REQ-031 Session DEADBEEF, sequence F0F0F0F0F0F0F0F0, count 1, len 14, beat 2 lanes 6-7 = FF FF, beat 3 all AA, beat 4 keep 0F BB x4 with tlast -> beat A: start=1, len=14, mask FF, data AAAAAAAAAAAAFFFF; beat B: mask 3F, data BBBBBBBBAAAA.
REQ-032 Same datagram with len 16 (truncated by tlast) -> beat A as above, then mask 3F flush, then IDLE.
REQ-033 Count 2, lengths 3 and 5, single tlast -> two beats, each start=1; masks 07 and 1F.
REQ-034 tuser=1 on beat 3 -> no mold_msg_v_o; the next datagram parses normally.
REQ-035 nreset pulse between beats 3 and 4 -> all outputs 0, no stale beat; the next datagram parses normally.
REQ-036 tvalid gaps inserted between every beat of REQ-031 -> identical output data, each beat delayed accordingly.
